// File: rtl/press_event_pkg.sv
// press_event_pkg: shared state encoding and default constants for the press gesture decoder.
package press_event_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  localparam int GAP_CYCLES_DEF = 30_000_000;
  localparam int EVT_CNT_W = 8;
endpackage

// File: rtl/press_gap_timer.sv
// press_gap_timer: clearable/enable gap counter with a terminal flag at GAP_CYCLES-1.
module press_gap_timer #(
  parameter int GAP_CYCLES = 30_000_000,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign done = cnt_q == CNT_W'(GAP_CYCLES - 1);
endmodule

// File: rtl/press_event_decoder.sv
// press_event_decoder: classifies debounced press pulses into tap / double tap / hold gestures.
// Optional PRESS_COUNT_EN adds a saturating event_count of tap, double_tap and hold_start.
module press_event_decoder
  import press_event_pkg::*;
#(
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic press_pulse,
  input  logic button_level,
  output logic tap,
  output logic double_tap,
  output logic hold_start,
  output logic hold_end,
`ifdef PRESS_COUNT_EN
  output logic [EVT_CNT_W-1:0] event_count,
`endif
  output logic holding
);
  state_t state_q, state_d;
  logic released_q, released_d;
  logic rel_now, in_wait, timer_done;
  logic tap_d, double_tap_d, hold_start_d, hold_end_d;
  logic tap_q, double_tap_q, hold_start_q, hold_end_q;
  assign in_wait = state_q == WAIT;
  // a release seen in the same cycle as the second pulse still counts as released
  assign rel_now = released_q | ~button_level;
  press_gap_timer #(.GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == IDLE && press_pulse),
    .en   (in_wait),
    .done (timer_done)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      released_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      released_q <= released_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = press_pulse ? WAIT : IDLE;
      WAIT: state_d = press_pulse ? (rel_now ? IDLE : HOLD) : (timer_done ? IDLE : WAIT);
      HOLD: state_d = button_level ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    released_d   = in_wait & rel_now;
    tap_d        = in_wait & ~press_pulse & timer_done;
    double_tap_d = in_wait & press_pulse & rel_now;
    hold_start_d = in_wait & press_pulse & ~rel_now;
    hold_end_d   = (state_q == HOLD) & ~button_level;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q        <= 1'b0;
      double_tap_q <= 1'b0;
      hold_start_q <= 1'b0;
      hold_end_q   <= 1'b0;
    end else begin
      tap_q        <= tap_d;
      double_tap_q <= double_tap_d;
      hold_start_q <= hold_start_d;
      hold_end_q   <= hold_end_d;
    end
  end
  assign tap        = tap_q;
  assign double_tap = double_tap_q;
  assign hold_start = hold_start_q;
  assign hold_end   = hold_end_q;
  assign holding    = state_q == HOLD;
`ifdef PRESS_COUNT_EN
  logic [EVT_CNT_W-1:0] count_q, count_d;
  always_comb count_d = (tap_d | double_tap_d | hold_start_d) && !(&count_q) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  end
  assign event_count = count_q;
`endif
endmodule

// File: tb/tb_press_event_decoder.sv
// tb_press_event_decoder: directed gesture scenarios plus random stimulus against a timestamp-based model.
module tb_press_event_decoder;
  localparam int GAP = 10;
  logic clk = 1'b0, rst_n = 1'b0, press_pulse = 1'b0, button_level = 1'b0;
  logic tap, double_tap, hold_start, hold_end, holding;
`ifdef PRESS_COUNT_EN
  logic [7:0] event_count;
`endif
  int n_chk = 0, n_fail = 0, cyc = 0;
  int m_start, m_cnt;
  bit m_rel, m_hold;
  logic [3:0] m_ev;
  int obs[4];

  press_event_decoder #(.GAP_CYCLES(GAP), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .press_pulse (press_pulse),
    .button_level(button_level),
    .tap         (tap),
    .double_tap  (double_tap),
    .hold_start  (hold_start),
    .hold_end    (hold_end),
`ifdef PRESS_COUNT_EN
    .event_count (event_count),
`endif
    .holding     (holding)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_start = -1;
    m_rel = 1'b0;
    m_hold = 1'b0;
    m_cnt = 0;
    m_ev = '0;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 4; i++) obs[i] = -1;
  endtask

  // One clock: apply inputs for cycle cyc, predict, then compare in cycle cyc+1.
  task automatic step(input bit p, input bit l);
    logic [3:0] ev;
    bit r;
    press_pulse = p;
    button_level = l;
    m_ev = '0;
    if (m_hold) begin
      if (!l) begin
        m_ev[3] = 1'b1;
        m_hold = 1'b0;
      end
    end else if (m_start >= 0) begin
      r = m_rel || !l;
      if (p) begin
        if (r) m_ev[1] = 1'b1;
        else begin
          m_ev[2] = 1'b1;
          m_hold = 1'b1;
        end
        m_start = -1;
      end else if (cyc - m_start == GAP - 1) begin
        m_ev[0] = 1'b1;
        m_start = -1;
      end else m_rel = r;
    end else if (p) begin
      m_start = cyc + 1;
      m_rel = 1'b0;
    end
    if (|m_ev[2:0] && m_cnt < 255) m_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    ev = {hold_end, hold_start, double_tap, tap};
    check("events", int'(ev), int'(m_ev));
    check("holding", int'(holding), int'(m_hold));
`ifdef PRESS_COUNT_EN
    check("event_count", int'(event_count), m_cnt);
`endif
    for (int i = 0; i < 4; i++) if (ev[i]) obs[i] = cyc;
  endtask

  task automatic rst_cycles(input int n);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < n; i++) begin
      press_pulse = ~press_pulse;
      button_level = ~button_level;
      check("rst_outputs", int'({tap, double_tap, hold_start, hold_end, holding}), 0);
`ifdef PRESS_COUNT_EN
      check("rst_count", int'(event_count), 0);
`endif
      @(posedge clk);
      #1;
      cyc++;
    end
    rst_n = 1'b1;
    press_pulse = 1'b0;
    button_level = 1'b0;
    model_reset();
  endtask

  task automatic new_scenario();
    rst_cycles(2);
    cyc = 0;
    clear_obs();
  endtask

  initial begin
    bit lvl, p;
    model_reset();
    clear_obs();
    rst_cycles(4);
    cyc = 0;
    for (int c = 0; c < 8; c++) step(1'b0, c[0]);
    new_scenario();
    for (int c = 0; c < 20; c++) step(c == 5, c < 7);
    check("sc2_tap_at", obs[0], 16);
    check("sc2_no_dbl", obs[1], -1);
    check("sc2_no_hold", obs[2], -1);
    new_scenario();
    for (int c = 0; c < 24; c++) step(c == 5 || c == 11, !(c >= 7 && c < 11) && c < 13);
    check("sc3_dbl_at", obs[1], 12);
    check("sc3_no_tap", obs[0], -1);
    new_scenario();
    for (int c = 0; c < 26; c++) step(c == 5 || c == 9, c < 20);
    check("sc4_hs_at", obs[2], 10);
    check("sc4_he_at", obs[3], 21);
    check("sc4_no_tap", obs[0], -1);
    new_scenario();
    for (int c = 0; c < 30; c++) step(c == 5 || c == 15, c == 5 || c == 15);
    check("sc5_dbl_at", obs[1], 16);
    check("sc5_no_tap", obs[0], -1);
    new_scenario();
    for (int c = 0; c < 8; c++) step(c == 5, c >= 5);
    rst_cycles(2);
    for (int c = 10; c < 30; c++) step(c == 12, c == 12);
    check("sc6_tap_at", obs[0], 23);
    check("sc6_no_dbl", obs[1], -1);
`ifdef PRESS_COUNT_EN
    check("sc6_count", int'(event_count), 1);
`endif
    new_scenario();
    for (int c = 0; c < 16; c++) step(c == 5 || c == 8, c == 5);
    check("sc7_rel_with_pulse_dbl", obs[1], 9);
    check("sc7_no_hs", obs[2], -1);
    new_scenario();
    lvl = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (i < 1500 && $urandom_range(0, 999) == 0) rst_cycles(1);
      if ($urandom_range(0, 4) == 0) lvl = ~lvl;
      p = $urandom_range(0, 6) == 0;
      step(p, p ? ($urandom_range(0, 3) != 0) : lvl);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
